fetch_queue: RTL and testbench

//  Instruction-fetch stage directly upstream of the arm core: drives instruction-memory requests over a req/ack handshake.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue_fifo.sv | 67 ++++++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue: FSM encoding,
// queue entry layout, default NOP word and word-size helpers.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT       = 2'd1,
    ST_WAIT_STALE = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0;
  localparam logic [31:0] WORD_BYTES    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory request/ack, core instruction and redirect signals of the fetch stage.
// master = fetch_queue side, slave = memory plus core side.
interface fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_take, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_take, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry circular buffer of {pc, instr}; push visible at head next cycle.
// Push and pop together are allowed when full; a push into a full queue without pop is dropped.
module fetch_queue_fifo import fetch_queue_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fq_entry_t                    push_dat_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output fq_entry_t                    head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues word requests while queue credit remains, buffers responses, flushes on redirect.
// Ack in cycle N shows at an empty head in N+1; requests stop once queued plus in-flight words reach DEPTH.
module fetch_queue import fetch_queue_pkg::*; #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] fifo_cnt, cnt_nxt;
  fq_entry_t     head, push_dat;
  logic          valid, xfer, flush, push, pop, credit;
  logic [31:0]   rpc, pc_inc;

  assign valid    = fifo_cnt != '0;
  assign xfer     = (state_q != ST_IDLE) && bus.mem_ack;
  assign flush    = bus.redirect;
  assign push     = (state_q == ST_WAIT) && xfer && !flush;
  assign pop      = bus.instr_take && valid && !flush;
  assign rpc      = word_align(bus.redirect_pc);
  assign pc_inc   = fetch_pc_q + WORD_BYTES;
  assign push_dat = '{pc: addr_q, instr: bus.mem_rdata};

  // Occupancy after this cycle's push/take/flush; one more request fits if below DEPTH.
  always_comb begin
    cnt_nxt = fifo_cnt;
    if (flush)              cnt_nxt = '0;
    else if (push && !pop)  cnt_nxt = fifo_cnt + CW'(1);
    else if (pop && !push)  cnt_nxt = fifo_cnt - CW'(1);
  end
  assign credit = cnt_nxt < FULL;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          fetch_pc_d = rpc;
          addr_d     = rpc;
          state_d    = ST_WAIT;
        end else if (credit) begin
          addr_d  = fetch_pc_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          fetch_pc_d = rpc;
          // Address must not move mid-request, so a redirect without ack waits out the old transfer.
          if (xfer) addr_d  = rpc;
          else      state_d = ST_WAIT_STALE;
        end else if (xfer) begin
          fetch_pc_d = pc_inc;
          if (credit) addr_d  = pc_inc;
          else        state_d = ST_IDLE;
        end
      end
      ST_WAIT_STALE: begin
        if (flush) fetch_pc_d = rpc;
        if (xfer) begin
          addr_d  = flush ? rpc : fetch_pc_q;
          state_d = credit ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .count_o    (fifo_cnt),
    .head_o     (head)
  );

  assign bus.mem_req     = state_q != ST_IDLE;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? head.instr : NOP_INSTR;
  assign bus.instr_pc    = valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenarios plus random ack/take/redirect traffic, scored against an
// expected-PC-stream model and a memory whose word is a fixed function of its address.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'hE1A0_0000;

  logic clk = 1'b0;
  logic reset;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          lat;
  bit          lat_rand, take_once, ack_force, rst_nxt;
  int          take_mode;
  int          age;
  logic [31:0] exp_pc, prev_addr;
  bit          prev_hold, last_xfer;
  logic [31:0] xfer_log [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, score the cycle, return 1ns after the posedge.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit ack, tk;
    @(negedge clk);
    reset = rst_nxt;
    tk = (take_mode == 1) || take_once || (take_mode == 2 && $urandom_range(0, 1) == 1);
    take_once = 1'b0;
    if (ack_force)     ack = 1'b1;
    else if (lat_rand) ack = bus.mem_req && ($urandom_range(0, 2) == 0);
    else               ack = bus.mem_req && (age >= lat);
    bus.mem_ack     = ack;
    bus.mem_rdata   = mem_word(bus.mem_addr);
    bus.instr_take  = tk;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (rst_nxt) begin
      exp_pc    = RESET_PC;
      prev_hold = 1'b0;
    end else begin
      if (bus.instr_valid) chk("word", bus.instr, mem_word(bus.instr_pc));
      else begin
        chk("nop_instr", bus.instr, NOP);
        chk("nop_pc", bus.instr_pc, 32'h0);
      end
      if (prev_hold) begin
        chk("req_hold", 32'(bus.mem_req), 32'd1);
        chk("addr_hold", bus.mem_addr, prev_addr);
      end
      chk("no_overflow", 32'(dut.push && (32'(dut.fifo_cnt) == DEPTH) && !dut.pop), 32'd0);
      if (redir) exp_pc = {rpc[31:2], 2'b00};
      else if (tk && bus.instr_valid) begin
        chk("order", bus.instr_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      prev_hold = bus.mem_req && !ack;
      prev_addr = bus.mem_addr;
    end
    last_xfer = bus.mem_req && ack && !rst_nxt;
    if (last_xfer) xfer_log.push_back(bus.mem_addr);
    if (!bus.mem_req || last_xfer || rst_nxt) age = 0;
    else age++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_nxt   = 1'b1;
    ack_force = 1'b0;
    take_once = 1'b0;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_pc", bus.instr_pc, 32'h0);
    rst_nxt = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          found;
    logic [31:0] rr;
    reset = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; bus.instr_take = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    rst_nxt = 1'b1; lat = 0; lat_rand = 1'b0; take_mode = 0; age = 0;
    exp_pc = RESET_PC; prev_hold = 1'b0; prev_addr = 32'h0; last_xfer = 1'b0;

    // Zero-wait memory, core always taking: one instruction per cycle.
    lat = 0; take_mode = 1; reset_dut();
    step(1'b0, 32'h0);
    chk("t1_req", 32'(bus.mem_req), 32'd1);
    chk("t1_addr", bus.mem_addr, RESET_PC);
    step(1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", 32'(bus.instr_valid), 32'd1);
      chk("t1_pc", bus.instr_pc, RESET_PC + 32'(4 * k));
      step(1'b0, 32'h0);
    end

    // Slow memory, no takes: exactly DEPTH requests, then one take reopens credit.
    lat = 2; take_mode = 0; reset_dut(); xfer_log.delete();
    repeat (30) step(1'b0, 32'h0);
    chk("t2_nreq", 32'(xfer_log.size()), 32'(DEPTH));
    foreach (xfer_log[i]) chk("t2_addr", xfer_log[i], 32'(4 * i));
    chk("t2_idle", 32'(bus.mem_req), 32'd0);
    chk("t2_cnt", 32'(dut.fifo_cnt), 32'(DEPTH));
    take_once = 1'b1;
    step(1'b0, 32'h0);
    chk("t2_req2", 32'(bus.mem_req), 32'd1);
    chk("t2_addr2", bus.mem_addr, 32'h10);
    chk("t2_head", bus.instr_pc, 32'h4);

    // Redirect while the request to 0x8 is pending: address held, stale word dropped.
    lat = 3; take_mode = 1; reset_dut();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.mem_req && bus.mem_addr == 32'h8) found = 1'b1;
      else step(1'b0, 32'h0);
    end
    chk("t3_reach", 32'(found), 32'd1);
    step(1'b1, 32'h100);
    chk("t3_hold", bus.mem_addr, 32'h8);
    chk("t3_req", 32'(bus.mem_req), 32'd1);
    chk("t3_flushed", 32'(bus.instr_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0);
      found = last_xfer;
    end
    chk("t3_stale_ack", 32'(found), 32'd1);
    chk("t3_newaddr", bus.mem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.instr_valid) found = 1'b1;
      else step(1'b0, 32'h0);
    end
    chk("t3_valid", 32'(found), 32'd1);
    chk("t3_first", bus.instr_pc, 32'h100);

    // Redirect, ack and take together; the new target also exercises PC wrap.
    lat = 0; take_mode = 1; reset_dut();
    repeat (5) step(1'b0, 32'h0);
    chk("t4_pre", 32'(bus.instr_valid && bus.mem_req), 32'd1);
    step(1'b1, 32'hFFFF_FFFB);
    chk("t4_valid", 32'(bus.instr_valid), 32'd0);
    chk("t4_instr", bus.instr, NOP);
    chk("t4_req", 32'(bus.mem_req), 32'd1);
    chk("t4_addr", bus.mem_addr, 32'hFFFF_FFF8);
    step(1'b0, 32'h0);
    chk("t4_pc0", bus.instr_pc, 32'hFFFF_FFF8);
    step(1'b0, 32'h0);
    chk("t4_pc1", bus.instr_pc, 32'hFFFF_FFFC);
    step(1'b0, 32'h0);
    chk("t4_wrap", bus.instr_pc, 32'h0);

    // Full queue: stray acks change nothing; take+ack together keep occupancy steady.
    lat = 0; take_mode = 0; reset_dut();
    repeat (8) step(1'b0, 32'h0);
    chk("t5_full", 32'(dut.fifo_cnt), 32'(DEPTH));
    chk("t5_idle", 32'(bus.mem_req), 32'd0);
    ack_force = 1'b1;
    repeat (3) step(1'b0, 32'h0);
    chk("t5_stray", 32'(dut.fifo_cnt), 32'(DEPTH));
    chk("t5_head", bus.instr_pc, 32'h0);
    take_mode = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0);
      chk("t5_steady", 32'(dut.fifo_cnt), 32'(DEPTH - 1));
    end
    take_mode = 0; ack_force = 1'b0;
    repeat (6) step(1'b0, 32'h0);
    chk("t5_refill", 32'(dut.fifo_cnt), 32'(DEPTH));
    chk("t5_head2", bus.instr_pc, exp_pc);
    take_mode = 1;
    repeat (4) step(1'b0, 32'h0);

    // Reset in the middle of a live request.
    lat = 1; take_mode = 0; reset_dut();
    repeat (5) step(1'b0, 32'h0);
    for (int i = 0; i < 10 && !bus.mem_req; i++) step(1'b0, 32'h0);
    chk("t6_pre", 32'(bus.mem_req), 32'd1);
    rst_nxt = 1'b1;
    step(1'b0, 32'h0);
    chk("t6_req", 32'(bus.mem_req), 32'd0);
    chk("t6_valid", 32'(bus.instr_valid), 32'd0);
    rst_nxt = 1'b0;
    step(1'b0, 32'h0);
    chk("t6_req1", 32'(bus.mem_req), 32'd1);
    chk("t6_addr", bus.mem_addr, RESET_PC);

    // Random latency, takes and redirects (some near the top of the address space).
    lat_rand = 1'b1; take_mode = 2; reset_dut();
    for (int i = 0; i < 1500; i++) begin
      rr = $urandom;
      if ($urandom_range(0, 3) == 0) rr[31:4] = '1;
      step($urandom_range(0, 19) == 0, rr);
    end
    lat_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
